// File: rtl/video_pkg.sv
// Shared timing defaults (1080p60) and raster state encoding for the video output path.
package video_pkg;

    localparam int DEF_H_ACTIVE   = 1920;
    localparam int DEF_H_FP       = 88;
    localparam int DEF_H_SYNC     = 44;
    localparam int DEF_H_BP       = 148;
    localparam int DEF_V_ACTIVE   = 1080;
    localparam int DEF_V_FP       = 4;
    localparam int DEF_V_SYNC     = 5;
    localparam int DEF_V_BP       = 36;
    localparam int DEF_FIFO_DEPTH = 4096;
    localparam int DEF_PREFILL    = 2048;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vstate_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO, head visible combinationally, level updated one clock after push/pop.
// A push while full is accepted only if a pop happens the same cycle; otherwise it is ignored.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

endmodule

// File: rtl/video_timing_out.sv
// Raster timing generator fed from a pixel FIFO; outputs registered one clock after the counters.
// No backpressure: pixels arriving to a full FIFO are dropped (sticky overflow), empty FIFO outputs black (sticky underflow).
module video_timing_out
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PREFILL    = DEF_PREFILL,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [23:0]                   pixel_data_in,
    input  logic                          pixel_valid_in,
    input  logic                          flag_clr,
    output logic [23:0]                   hdmi_rgb,
    output logic                          hdmi_de,
    output logic                          hdmi_hsync,
    output logic                          hdmi_vsync,
    output logic                          fifo_overflow,
    output logic                          fifo_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

    vstate_t         state;
    vstate_t         state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            active;
    logic            hs_on;
    logic            vs_on;
    logic            pop;
    logic            ovf_set;
    logic            udf_set;
    logic [23:0]     head_data;
    logic            fifo_full;
    logic            fifo_empty;

    pixel_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pixel_valid_in),
        .push_data (pixel_data_in),
        .pop       (pop),
        .pop_data  (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // RUN is only left through reset; the sync/active decode is gated so IDLE looks blank.
    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        hs_on     = 1'b0;
        vs_on     = 1'b0;
        if (state == IDLE) begin
            if (fifo_level >= PREFILL_L) state_nxt = RUN;
        end else begin
            active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
            vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);
        end
    end

    assign pop     = active && !fifo_empty;
    assign udf_set = active && fifo_empty;
    assign ovf_set = pixel_valid_in && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdmi_rgb       <= '0;
            hdmi_de        <= 1'b0;
            hdmi_hsync     <= !HS_POL;
            hdmi_vsync     <= !VS_POL;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            hdmi_rgb       <= pop ? head_data : '0;
            hdmi_de        <= active;
            hdmi_hsync     <= hs_on ? HS_POL : !HS_POL;
            hdmi_vsync     <= vs_on ? VS_POL : !VS_POL;
            // A new event in the clear cycle keeps the flag set.
            fifo_overflow  <= ovf_set || (fifo_overflow && !flag_clr);
            fifo_underflow <= udf_set || (fifo_underflow && !flag_clr);
        end
    end

endmodule

// File: tb/tb_video_timing_out.sv
// Bench for video_timing_out on an 8x6 raster with a 16-entry FIFO; a queue-based frame model is compared every cycle.
module tb_video_timing_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel_data_in;
    logic        pixel_valid_in;
    logic        flag_clr;
    logic [23:0] hdmi_rgb;
    logic        hdmi_de;
    logic        hdmi_hsync;
    logic        hdmi_vsync;
    logic        fifo_overflow;
    logic        fifo_underflow;
    logic [4:0]  fifo_level;

    always #5 clk = ~clk;

    video_timing_out #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_DEPTH(16), .PREFILL(8), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_data_in  (pixel_data_in),
        .pixel_valid_in (pixel_valid_in),
        .flag_clr       (flag_clr),
        .hdmi_rgb       (hdmi_rgb),
        .hdmi_de        (hdmi_de),
        .hdmi_hsync     (hdmi_hsync),
        .hdmi_vsync     (hdmi_vsync),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow),
        .fifo_level     (fifo_level)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: position follows from the number of cycles spent running.
    logic [23:0] mq[$];
    bit          m_ok = 1'b0;
    bit          m_run;
    int          m_t;
    logic        m_de, m_hs, m_vs, m_ov, m_un;
    logic [23:0] m_rgb;
    logic [4:0]  m_lvl;
    int          mh, mv, mpre;
    bit          mact, mpop, macc;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ok = 1'b1; m_run = 1'b0; m_t = 0;
            m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_ov = 1'b0; m_un = 1'b0;
            m_rgb = '0; m_lvl = '0;
        end else begin
            mpre  = mq.size();
            mh    = m_t % 8;
            mv    = (m_t / 8) % 6;
            mact  = m_run && mh < 4 && mv < 3;
            mpop  = mact && mpre > 0;
            m_de  = mact;
            m_rgb = mpop ? mq[0] : 24'h0;
            m_hs  = m_run && mh >= 5 && mh < 7;
            m_vs  = m_run && mv == 4;
            macc  = pixel_valid_in && (mpre < 16 || mpop);
            m_ov  = (pixel_valid_in && !macc) || (m_ov && !flag_clr);
            m_un  = (mact && mpre == 0) || (m_un && !flag_clr);
            if (mpop) void'(mq.pop_front());
            if (macc) mq.push_back(pixel_data_in);
            m_lvl = 5'(mq.size());
            if (m_run) m_t++;
            else if (mpre >= 8) begin m_run = 1'b1; m_t = 0; end
        end
    end

    // Observed-output history
    logic [23:0] seen[$];
    int  cyc = 0, last_rise = -1, de_cnt = 0, hs_cnt = 0;
    int  per_period = 0, per_de = 0, per_hs = 0, n_per = 0;
    logic prev_vs = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_ok)
            check("cycle_outputs",
                  64'({hdmi_de, hdmi_hsync, hdmi_vsync, fifo_overflow, fifo_underflow, fifo_level, hdmi_rgb}),
                  64'({m_de, m_hs, m_vs, m_ov, m_un, m_lvl, m_rgb}));
        if (hdmi_vsync && !prev_vs) begin
            if (last_rise >= 0) begin
                per_period = cyc - last_rise; per_de = de_cnt; per_hs = hs_cnt; n_per++;
            end
            last_rise = cyc; de_cnt = 0; hs_cnt = 0;
        end
        if (hdmi_de) begin de_cnt++; seen.push_back(hdmi_rgb); end
        if (hdmi_hsync) hs_cnt++;
        prev_vs = hdmi_vsync;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [23:0] d, input logic clr);
        pixel_valid_in = v;
        pixel_data_in  = d;
        flag_clr       = clr;
        tick();
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_de"},    64'(hdmi_de),        64'd0);
        check({tag, "_rgb"},   64'(hdmi_rgb),       64'd0);
        check({tag, "_hs"},    64'(hdmi_hsync),     64'd0);
        check({tag, "_vs"},    64'(hdmi_vsync),     64'd0);
        check({tag, "_level"}, 64'(fifo_level),     64'd0);
        check({tag, "_ovf"},   64'(fifo_overflow),  64'd0);
        check({tag, "_udf"},   64'(fifo_underflow), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 24'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int  base;
        int  cnt;
        bit  done;
        bit  found;

        rst_n = 1'b0; pixel_valid_in = 1'b0; pixel_data_in = '0; flag_clr = 1'b0;

        // Prefill and raster timing with continuous supply
        do_reset();
        check_blank("reset");
        for (int i = 0; i < 7; i++) drive(1'b1, 24'hA00 + 24'(i), 1'b0);
        repeat (3) drive(1'b0, 24'h0, 1'b0);
        check("prefill7_de", 64'(hdmi_de), 64'd0);
        check("prefill7_level", 64'(fifo_level), 64'd7);
        drive(1'b1, 24'hA07, 1'b0);
        check("prefill8_level", 64'(fifo_level), 64'd8);
        drive(1'b1, 24'hA08, 1'b0);
        check("run_entry_de", 64'(hdmi_de), 64'd0);
        drive(1'b1, 24'hA09, 1'b0);
        check("first_de", 64'(hdmi_de), 64'd1);
        check("first_rgb", 64'(hdmi_rgb), 64'hA00);
        for (int i = 0; i < 120; i++) drive(1'b1, 24'hA0A + 24'(i), 1'b0);
        check("frame_periods_seen", 64'(n_per >= 1), 64'd1);
        check("frame_period", 64'(per_period), 64'd48);
        check("de_per_frame", 64'(per_de), 64'd12);
        check("hs_per_frame", 64'(per_hs), 64'd12);

        // Underflow after 10 pixels
        do_reset();
        base = seen.size();
        for (int i = 0; i < 10; i++) drive(1'b1, 24'hB00 + 24'(i), 1'b0);
        repeat (40) drive(1'b0, 24'h0, 1'b0);
        check("udf_count", 64'(seen.size() >= base + 12), 64'd1);
        if (seen.size() >= base + 12) begin
            for (int i = 0; i < 10; i++) check("udf_order", 64'(seen[base + i]), 64'hB00 + 64'(i));
            check("udf_black0", 64'(seen[base + 10]), 64'd0);
            check("udf_black1", 64'(seen[base + 11]), 64'd0);
        end
        check("udf_flag", 64'(fifo_underflow), 64'd1);

        // Overflow while the raster is in vertical blanking
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 24'hC80 + 24'(i), 1'b0);
        base = seen.size();
        cnt = 0; done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            drive(1'b0, 24'h0, 1'b0);
            if (hdmi_de) cnt++;
            else if (cnt == 12) done = 1'b1;
        end
        check("wait_blank_done", 64'(done), 64'd1);
        for (int i = 0; i < 17; i++) drive(1'b1, 24'hC00 + 24'(i), 1'b0);
        check("ovf_level", 64'(fifo_level), 64'd16);
        check("ovf_flag", 64'(fifo_overflow), 64'd1);
        drive(1'b0, 24'h0, 1'b1);
        check("ovf_clr", 64'(fifo_overflow), 64'd0);

        // Push into a full FIFO alongside active pops, then clear coincident with a drop
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive(1'b0, 24'h0, 1'b0);
            if (!hdmi_vsync) done = 1'b1;
        end
        check("wait_vs_fall_done", 64'(done), 64'd1);
        repeat (7) drive(1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 24'hD00 + 24'(i), 1'b0);
        check("full_pop_push_level", 64'(fifo_level), 64'd16);
        check("full_pop_push_ovf", 64'(fifo_overflow), 64'd0);
        drive(1'b1, 24'hDEE, 1'b1);
        check("clr_vs_set_ovf", 64'(fifo_overflow), 64'd1);
        repeat (96) drive(1'b0, 24'h0, 1'b0);
        found = 1'b0;
        for (int i = base; i < seen.size(); i++)
            if (seen[i] == 24'hC10 || seen[i] == 24'hDEE) found = 1'b1;
        check("dropped_never_output", 64'(found), 64'd0);

        // Mid-frame reset at line 1
        repeat (4) drive(1'b0, 24'h0, 1'b0);
        do_reset();
        check_blank("midreset");
        for (int i = 0; i < 7; i++) drive(1'b1, 24'hE00 + 24'(i), 1'b0);
        repeat (3) drive(1'b0, 24'h0, 1'b0);
        check("reprefill7_de", 64'(hdmi_de), 64'd0);
        check("reprefill7_level", 64'(fifo_level), 64'd7);
        drive(1'b1, 24'hE07, 1'b0);
        drive(1'b0, 24'h0, 1'b0);
        check("rerun_entry_de", 64'(hdmi_de), 64'd0);
        drive(1'b0, 24'h0, 1'b0);
        check("rerun_first_de", 64'(hdmi_de), 64'd1);
        check("rerun_first_rgb", 64'(hdmi_rgb), 64'hE00);
        repeat (20) drive(1'b0, 24'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
